// File: rtl/register_scoreboard.sv
// register_scoreboard: decode-stage RAW/WAW interlock for the 5-stage core.
// Keeps a small saturating count of in-flight writes per architectural register,
// raises the decode stall for dirty operands or a full counter, and runs a
// drain sequencer (RUN -> DRAIN -> ACK -> HOLD/RUN) for fence/CSR/flush logic.
// Optional build macro SCOREBOARD_STATS_EN adds stall_cycles/drain_cycles counters.
module register_scoreboard #(
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int NUM_REGS             = 32,
    parameter int PENDING_WIDTH        = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid,
    input  logic [6:0]                      issue_op_code,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_2,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_dst,
    input  logic                            rf_write_en,
    input  logic [REGISTER_INDEX_WIDTH-1:0] rf_write_idx,
    input  logic                            drain_req,
    output logic                            stall,
    output logic                            issue_fire,
    output logic                            drain_ack,
    output logic [NUM_REGS-1:0]             busy_mask
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                     stall_cycles,
    output logic [31:0]                     drain_cycles
`else
    // statistics outputs are not present in this build
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [PENDING_WIDTH-1:0] PEND_ONE = {{(PENDING_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = {PENDING_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [PENDING_WIDTH-1:0] pending_q [NUM_REGS];
    logic [PENDING_WIDTH-1:0] pending_d [NUM_REGS];
    logic [NUM_REGS-1:0]      inc_vec, dec_vec;
    logic                     use_rs1, use_rs2, writes_rd;
    logic                     src1_hz, src2_hz, rd_full;
    logic                     all_clear_d;

    // Decode which operands the instruction reads and whether it writes rd.
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (issue_op_code)
            OP_R:                 begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_STORE, OP_BRANCH:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LOAD, OP_IMM,
            OP_JALR:              begin use_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_LUI, OP_AUIPC,
            OP_JAL:               writes_rd = 1'b1;
            default:              ;
        endcase
    end

    // Hazard detection; a same-cycle retire that empties a source (or frees a
    // slot in a full rd counter) lets the instruction through.
    always_comb begin
        src1_hz = use_rs1 && (issue_idx_src_1 != '0) && (pending_q[issue_idx_src_1] != '0)
                  && !(rf_write_en && (rf_write_idx == issue_idx_src_1)
                       && (pending_q[issue_idx_src_1] == PEND_ONE));
        src2_hz = use_rs2 && (issue_idx_src_2 != '0) && (pending_q[issue_idx_src_2] != '0)
                  && !(rf_write_en && (rf_write_idx == issue_idx_src_2)
                       && (pending_q[issue_idx_src_2] == PEND_ONE));
        rd_full = writes_rd && (issue_idx_dst != '0) && (pending_q[issue_idx_dst] == PEND_MAX)
                  && !(rf_write_en && (rf_write_idx == issue_idx_dst));
        stall      = issue_valid && (src1_hz || src2_hz || rd_full || (state_q != ST_RUN));
        issue_fire = issue_valid && !stall;
    end

    // Per-register increment (accepted writer) and decrement (retire) requests.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_fire && writes_rd
                         && (issue_idx_dst == REGISTER_INDEX_WIDTH'(r));
            dec_vec[r] = rf_write_en && (rf_write_idx == REGISTER_INDEX_WIDTH'(r))
                         && (pending_q[r] != '0);
        end
    end

    // Next pending counts; inc and dec together cancel, x0 stays empty.
    always_comb begin
        all_clear_d = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                pending_d[r] = pending_q[r] + PEND_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                pending_d[r] = pending_q[r] - PEND_ONE;
            end
        end
        pending_d[0] = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (pending_d[r] != '0) begin
                all_clear_d = 1'b0;
            end
        end
    end

    // Busy view of the registered counters.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_mask[r] = (pending_q[r] != '0);
        end
    end

    // Drain sequencer next-state and acknowledge output.
    always_comb begin
        state_d   = state_q;
        drain_ack = 1'b0;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (all_clear_d) state_d = ST_ACK;
            ST_ACK: begin
                drain_ack = 1'b1;
                state_d   = drain_req ? ST_HOLD : ST_RUN;
            end
            ST_HOLD:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] drain_cycles_q, drain_cycles_d;

    // Saturating event counters for stalled decode cycles and drain cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        drain_cycles_d = drain_cycles_q;
        if (issue_valid && stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((state_q == ST_DRAIN) && (drain_cycles_q != 32'hFFFF_FFFF)) begin
            drain_cycles_d = drain_cycles_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            drain_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            drain_cycles_q <= drain_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign drain_cycles = drain_cycles_q;
`else
    // no statistics counters in this build
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Testbench for register_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of pending-writer counts and the drain sequence.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [6:0]  issue_op_code = 7'd0;
    logic [4:0]  issue_idx_src_1 = 5'd0;
    logic [4:0]  issue_idx_src_2 = 5'd0;
    logic [4:0]  issue_idx_dst = 5'd0;
    logic        rf_write_en = 1'b0;
    logic [4:0]  rf_write_idx = 5'd0;
    logic        drain_req = 1'b0;
    logic        stall, issue_fire, drain_ack;
    logic [31:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, drain_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit run_chk = 1'b0;

    // model: outstanding writes per register and drain phase
    // phase 0 = normal issue, 1 = draining, 2 = acknowledging, 3 = holding
    int pend [32];
    int phase;

    register_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_op_code   (issue_op_code),
        .issue_idx_src_1 (issue_idx_src_1),
        .issue_idx_src_2 (issue_idx_src_2),
        .issue_idx_dst   (issue_idx_dst),
        .rf_write_en     (rf_write_en),
        .rf_write_idx    (rf_write_idx),
        .drain_req       (drain_req),
        .stall           (stall),
        .issue_fire      (issue_fire),
        .drain_ack       (drain_ack),
        .busy_mask       (busy_mask)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .drain_cycles    (drain_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011,
                          7'b0000011, 7'b0010011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit has_rd(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
                          7'b0110111, 7'b0010111, 7'b1101111};
    endfunction

    // a source blocks unless it is clean or retires its last writer this cycle
    function automatic bit src_blocks(input logic [4:0] s);
        if (s == 0 || pend[s] == 0) return 1'b0;
        if (rf_write_en && rf_write_idx == s && pend[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        if (!issue_valid) return 1'b0;
        if (phase != 0) return 1'b1;
        if (reads_rs1(issue_op_code) && src_blocks(issue_idx_src_1)) return 1'b1;
        if (reads_rs2(issue_op_code) && src_blocks(issue_idx_src_2)) return 1'b1;
        if (has_rd(issue_op_code) && issue_idx_dst != 0 && pend[issue_idx_dst] == 3
            && !(rf_write_en && rf_write_idx == issue_idx_dst)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] m = '0;
        for (int i = 1; i < 32; i++) if (pend[i] > 0) m[i] = 1'b1;
        return m;
    endfunction

    // model update on each clock edge, cleared asynchronously by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            phase = 0;
        end else begin
            bit fire;
            bit clear;
            fire = issue_valid && !m_stall();
            if (rf_write_en && rf_write_idx != 0 && pend[rf_write_idx] > 0)
                pend[rf_write_idx] = pend[rf_write_idx] - 1;
            if (fire && has_rd(issue_op_code) && issue_idx_dst != 0)
                pend[issue_idx_dst] = pend[issue_idx_dst] + 1;
            clear = 1'b1;
            for (int i = 0; i < 32; i++) if (pend[i] != 0) clear = 1'b0;
            case (phase)
                0: if (drain_req) phase = 1;
                1: if (clear) phase = 2;
                2: phase = drain_req ? 3 : 0;
                default: if (!drain_req) phase = 0;
            endcase
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run_chk) begin
            chk("stall", 32'(stall), 32'(m_stall()));
            chk("issue_fire", 32'(issue_fire), 32'(issue_valid && !m_stall()));
            chk("drain_ack", 32'(drain_ack), 32'(phase == 2));
            chk("busy_mask", busy_mask, m_busy());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        rf_write_en = 1'b0;
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] s1, input logic [4:0] s2);
        issue_valid     = 1'b1;
        issue_op_code   = op;
        issue_idx_dst   = rd;
        issue_idx_src_1 = s1;
        issue_idx_src_2 = s2;
    endtask

    task automatic set_retire(input logic [4:0] idx);
        rf_write_en  = 1'b1;
        rf_write_idx = idx;
    endtask

    initial begin
        // reset state
        #12;
        run_chk = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy_mask, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_ack", 32'(drain_ack), 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // add x3,x1,x2 then dependent sub x4,x3,x1 with bypass on retire of x3
        set_issue(7'b0110011, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        chk("add_fire", 32'(issue_fire), 32'h1);
        tick();
        set_issue(7'b0110011, 5'd4, 5'd3, 5'd1);
        @(negedge clk);
        chk("busy_x3", busy_mask, 32'h0000_0008);
        chk("sub_stall", 32'(stall), 32'h1);
        tick();
        set_retire(5'd3);
        @(negedge clk);
        chk("sub_bypass", 32'(stall), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("busy_after_sub", busy_mask, 32'h0000_0010);
        set_retire(5'd4);
        tick();
        idle();

        // three loads to x5, fourth stalls, then issues alongside a retire
        for (int k = 0; k < 3; k++) begin
            set_issue(7'b0000011, 5'd5, 5'd1, 5'd0);
            tick();
        end
        @(negedge clk);
        chk("model_pend5_3", 32'(pend[5]), 32'd3);
        chk("load4_stall", 32'(stall), 32'h1);
        tick();
        set_retire(5'd5);
        @(negedge clk);
        chk("load4_fire", 32'(issue_fire), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("model_pend5_still3", 32'(pend[5]), 32'd3);
        for (int k = 0; k < 3; k++) begin
            set_retire(5'd5);
            tick();
        end
        idle();

        // rd=0 write, retire of x0 and of a clean x7 have no effect
        set_issue(7'b0010011, 5'd0, 5'd1, 5'd0);
        set_retire(5'd0);
        tick();
        idle();
        set_retire(5'd7);
        tick();
        idle();
        @(negedge clk);
        chk("no_underflow", busy_mask, 32'h0);

        // drain with x3 and x6 pending
        set_issue(7'b0010011, 5'd3, 5'd0, 5'd0);
        tick();
        set_issue(7'b0010011, 5'd6, 5'd0, 5'd0);
        tick();
        idle();
        drain_req = 1'b1;
        tick();
        set_issue(7'b0110011, 5'd8, 5'd1, 5'd2);
        @(negedge clk);
        chk("drain_stall", 32'(stall), 32'h1);
        set_retire(5'd3);
        tick();
        set_retire(5'd6);
        @(negedge clk);
        chk("drain_no_ack_yet", 32'(drain_ack), 32'h0);
        tick();
        rf_write_en = 1'b0;
        @(negedge clk);
        chk("drain_ack_pulse", 32'(drain_ack), 32'h1);
        tick();
        @(negedge clk);
        chk("hold_ack_low", 32'(drain_ack), 32'h0);
        chk("hold_stall", 32'(stall), 32'h1);
        drain_req = 1'b0;
        tick();
        @(negedge clk);
        chk("run_again", 32'(issue_fire), 32'h1);
        tick();
        idle();
        set_retire(5'd8);
        tick();
        idle();

        // asynchronous reset while draining with x9 pending
        set_issue(7'b0010011, 5'd9, 5'd0, 5'd0);
        tick();
        idle();
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy_mask, 32'h0);
        chk("async_ack", 32'(drain_ack), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        set_issue(7'b0110011, 5'd10, 5'd9, 5'd9);
        @(negedge clk);
        chk("post_reset_x9", 32'(stall), 32'h0);
        tick();
        idle();
        set_retire(5'd10);
        tick();
        idle();

        // randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            int sel;
            logic [6:0] ops [11];
            ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
                    7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111,
                    7'b0001111};
            sel = $urandom_range(10, 0);
            issue_valid     = ($urandom_range(3, 0) != 0);
            issue_op_code   = ops[sel];
            issue_idx_dst   = 5'($urandom_range(7, 0));
            issue_idx_src_1 = 5'($urandom_range(7, 0));
            issue_idx_src_2 = 5'($urandom_range(7, 0));
            rf_write_en     = ($urandom_range(2, 0) != 0);
            rf_write_idx    = 5'($urandom_range(7, 0));
            if ($urandom_range(15, 0) == 0) drain_req = ~drain_req;
            tick();
        end
        idle();
        drain_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_retire(5'(k));
            tick();
            tick();
        end
        idle();
        tick();

`ifdef SCOREBOARD_STATS_EN
        // 4 stalled decode cycles then a 2-cycle drain
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        set_issue(7'b0010011, 5'd3, 5'd0, 5'd0);
        tick();
        set_issue(7'b0110011, 5'd4, 5'd3, 5'd3);
        repeat (4) tick();
        idle();
        drain_req = 1'b1;
        tick();
        tick();
        set_retire(5'd3);
        tick();
        idle();
        drain_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("stall_cycles", stall_cycles, 32'd4);
        chk("drain_cycles", drain_cycles, 32'd2);
`endif

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
